// File: rtl/seq_arith_unit.sv
// -----------------------------------------------------------------------------
// seq_arith_unit
//
// Multi-cycle arithmetic slice for the ALU datapath.
//   add/sub : result registered at the accept edge (single cycle).
//   mul     : iterative shift-add, WIDTH steps, full 2*WIDTH product.
//   div     : iterative restoring divider, WIDTH steps, {remainder, quotient}.
//   Signed mode works on magnitudes and fixes the signs on the final step.
//
// Handshake (valid/ready):
//   A start is accepted on a rising edge where the unit is IDLE and
//   Arith_Enable=1; operands, function and mode are captured on that edge.
//   While Busy=1 the unit is not ready and Arith_Enable is ignored. Every
//   completed operation raises Arith_Flag for exactly one cycle, and on that
//   cycle the unit is already IDLE, so a new start can be taken on the next edge.
//
// Ports:
//   CLK, RST       clock (rising edge), asynchronous active-low reset
//   A, B           operands (A = dividend, B = divisor for divide)
//   ALU_FUNC       00 add, 01 sub, 10 mul, 11 div
//   Signed_Mode    1 = two's complement operands
//   Arith_Enable   start request
//   Arith_OUT      result, held until the next completed operation
//   Carry_OUT      carry / borrow / overflow indicator
//   Arith_Flag     one-cycle result-valid pulse
//   Busy           high while mul/div iterates
//   Div_By_Zero    divide attempted with B == 0
//   state_dbg      1 while the FSM is in CALC (observation only)
// -----------------------------------------------------------------------------
module seq_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           ALU_FUNC,
  input  logic                 Signed_Mode,
  input  logic                 Arith_Enable,
  output logic [2*WIDTH-1:0]   Arith_OUT,
  output logic                 Carry_OUT,
  output logic                 Arith_Flag,
  output logic                 Busy,
  output logic                 Div_By_Zero,
  output logic                 state_dbg
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_DIV = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t            state;

  // Iteration registers. p_q is shared: for mul it is {partial high, multiplier
  // shifting out}, for div it is {partial remainder, dividend/quotient}.
  logic [W2-1:0]     p_q;
  logic [WIDTH-1:0]  opb_q;     // multiplicand or divisor magnitude
  logic              is_div_q;
  logic              sgn_q;
  logic              neg_q;     // final product / quotient must be negated
  logic              rneg_q;    // remainder takes dividend's sign
  logic              ovf_q;     // signed most-negative / -1 case
  logic [CW-1:0]     cnt_q;

  // Accept-edge combinational values
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    sum_u, dif_u;
  logic              ovf_add, ovf_sub;
  logic              div_ovf;

  // Iteration combinational values
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_next;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    div_diff;
  logic [W2-1:0]     div_next;
  logic [W2-1:0]     mul_res;
  logic              mul_carry;
  logic [WIDTH-1:0]  q_fin, r_fin;
  logic              last_step;

  always_comb begin
    a_neg    = Signed_Mode & A[WIDTH-1];
    b_neg    = Signed_Mode & B[WIDTH-1];
    // ~x+1 maps the most-negative value onto itself, which is its correct
    // unsigned magnitude.
    a_mag    = a_neg ? (~A + WIDTH'(1)) : A;
    b_mag    = b_neg ? (~B + WIDTH'(1)) : B;

    sum_u    = {1'b0, A} + {1'b0, B};
    dif_u    = {1'b0, A} - {1'b0, B};   // MSB is the borrow (A < B)
    ovf_add  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_u[WIDTH-1] != A[WIDTH-1]);
    ovf_sub  = (A[WIDTH-1] != B[WIDTH-1]) && (dif_u[WIDTH-1] != A[WIDTH-1]);
    div_ovf  = Signed_Mode && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}});
  end

  always_comb begin
    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole register right, carry included.
    mul_sum  = {1'b0, p_q[W2-1:WIDTH]} + (p_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, p_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder and try a
    // subtraction; keep it only when it does not go negative.
    rem_sh   = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    if (div_diff[WIDTH])
      div_next = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    mul_res  = neg_q ? (~mul_next + W2'(1)) : mul_next;
    if (sgn_q)
      mul_carry = (mul_res[W2-1:WIDTH] != {WIDTH{mul_res[WIDTH-1]}});
    else
      mul_carry = |mul_res[W2-1:WIDTH];

    q_fin    = neg_q  ? (~div_next[WIDTH-1:0]  + WIDTH'(1)) : div_next[WIDTH-1:0];
    r_fin    = rneg_q ? (~div_next[W2-1:WIDTH] + WIDTH'(1)) : div_next[W2-1:WIDTH];

    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  assign state_dbg = (state == S_CALC);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      p_q         <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      Arith_OUT   <= '0;
      Carry_OUT   <= 1'b0;
      Arith_Flag  <= 1'b0;
      Busy        <= 1'b0;
      Div_By_Zero <= 1'b0;
    end else begin
      Arith_Flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Arith_Enable) begin
            case (ALU_FUNC)
              FN_ADD: begin
                Arith_OUT   <= {{WIDTH{1'b0}}, sum_u[WIDTH-1:0]};
                Carry_OUT   <= Signed_Mode ? ovf_add : sum_u[WIDTH];
                Div_By_Zero <= 1'b0;
                Arith_Flag  <= 1'b1;
              end
              FN_SUB: begin
                Arith_OUT   <= {{WIDTH{1'b0}}, dif_u[WIDTH-1:0]};
                Carry_OUT   <= Signed_Mode ? ovf_sub : dif_u[WIDTH];
                Div_By_Zero <= 1'b0;
                Arith_Flag  <= 1'b1;
              end
              default: begin
                if ((ALU_FUNC == FN_DIV) && (B == '0)) begin
                  // Divide by zero finishes immediately: quotient all ones,
                  // remainder is the raw dividend.
                  Arith_OUT   <= {A, {WIDTH{1'b1}}};
                  Carry_OUT   <= 1'b0;
                  Div_By_Zero <= 1'b1;
                  Arith_Flag  <= 1'b1;
                end else begin
                  state    <= S_CALC;
                  Busy     <= 1'b1;
                  p_q      <= {{WIDTH{1'b0}}, a_mag};
                  opb_q    <= b_mag;
                  is_div_q <= (ALU_FUNC == FN_DIV);
                  sgn_q    <= Signed_Mode;
                  neg_q    <= a_neg ^ b_neg;
                  rneg_q   <= a_neg;
                  ovf_q    <= div_ovf;
                  cnt_q    <= '0;
                end
              end
            endcase
          end
        end

        S_CALC: begin
          p_q   <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            state       <= S_IDLE;
            Busy        <= 1'b0;
            Arith_Flag  <= 1'b1;
            Div_By_Zero <= 1'b0;
            if (is_div_q) begin
              Arith_OUT <= {r_fin, q_fin};
              Carry_OUT <= ovf_q;
            end else begin
              Arith_OUT <= mul_res;
              Carry_OUT <= mul_carry;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_arith_unit
//
// Directed vectors with hand-computed results for seq_arith_unit (WIDTH=16).
// -----------------------------------------------------------------------------
module tb_seq_arith_unit;

  localparam int W = 16;
  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_MUL = 2'b10;
  localparam logic [1:0] F_DIV = 2'b11;

  logic           CLK;
  logic           RST;
  logic [W-1:0]   A, B;
  logic [1:0]     ALU_FUNC;
  logic           Signed_Mode;
  logic           Arith_Enable;
  logic [2*W-1:0] Arith_OUT;
  logic           Carry_OUT;
  logic           Arith_Flag;
  logic           Busy;
  logic           Div_By_Zero;
  logic           state_dbg;

  int n_vec  = 0;
  int n_miss = 0;
  int flag_cnt = 0;

  // expected {carry, div_by_zero, result}
  logic [2*W+1:0] exp_q[$];

  seq_arith_unit #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .A           (A),
    .B           (B),
    .ALU_FUNC    (ALU_FUNC),
    .Signed_Mode (Signed_Mode),
    .Arith_Enable(Arith_Enable),
    .Arith_OUT   (Arith_OUT),
    .Carry_OUT   (Carry_OUT),
    .Arith_Flag  (Arith_Flag),
    .Busy        (Busy),
    .Div_By_Zero (Div_By_Zero),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Each flag pulse spans exactly one falling edge.
  always @(negedge CLK) if (Arith_Flag === 1'b1) flag_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input logic [1:0] fn, input logic sg,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    ALU_FUNC = fn; Signed_Mode = sg; A = a; B = b; Arith_Enable = 1'b1;
    @(posedge CLK); #1;
    Arith_Enable = 1'b0;
  endtask

  // Called 1ns after the accept edge; counts edges until the flag shows up.
  task automatic wait_flag(output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = int'(Busy);
    while (Arith_Flag !== 1'b1 && edges < 40) begin
      @(posedge CLK); #1;
      edges++;
      busy_cyc += int'(Busy);
    end
  endtask

  task automatic check_result(input string tag, input int edges, input int busy_cyc,
                              input int exp_lat);
    logic [2*W+1:0] e;
    e = exp_q.pop_front();
    check({tag, "_flag"},  32'(Arith_Flag),  32'd1);
    check({tag, "_out"},   Arith_OUT,        e[2*W-1:0]);
    check({tag, "_carry"}, 32'(Carry_OUT),   32'(e[2*W+1]));
    check({tag, "_dbz"},   32'(Div_By_Zero), 32'(e[2*W]));
    check({tag, "_lat"},   edges,            exp_lat);
    check({tag, "_busy"},  busy_cyc,         exp_lat);
  endtask

  task automatic run_op(input string tag, input logic [1:0] fn, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_out, input logic exp_c,
                        input logic exp_dbz, input int exp_lat);
    int edges, busy_cyc;
    drive_start(fn, sg, a, b);
    exp_q.push_back({exp_c, exp_dbz, exp_out});
    wait_flag(edges, busy_cyc);
    check_result(tag, edges, busy_cyc, exp_lat);
    @(posedge CLK); #1;
    check({tag, "_pulse"}, 32'(Arith_Flag), 32'd0);
  endtask

  initial begin
    int edges, busy_cyc, f0;
    RST = 1'b0; A = '0; B = '0; ALU_FUNC = F_ADD; Signed_Mode = 1'b0; Arith_Enable = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out",   Arith_OUT,         32'h0);
    check("rst_carry", 32'(Carry_OUT),    32'd0);
    check("rst_flag",  32'(Arith_Flag),   32'd0);
    check("rst_busy",  32'(Busy),         32'd0);
    check("rst_dbz",   32'(Div_By_Zero),  32'd0);
    check("rst_state", 32'(state_dbg),    32'd0);
    @(negedge CLK) RST = 1'b1;

    // unsigned add/sub
    run_op("add_u_carry", F_ADD, 1'b0, 16'hFFFF, 16'h0001, 32'h00000000, 1'b1, 1'b0, 0);
    run_op("sub_u_borrow", F_SUB, 1'b0, 16'h0003, 16'h0005, 32'h0000FFFE, 1'b1, 1'b0, 0);
    run_op("add_u_plain", F_ADD, 1'b0, 16'h1200, 16'h0034, 32'h00001234, 1'b0, 1'b0, 0);

    // unsigned mul, then back-to-back start with Arith_Enable held high
    @(negedge CLK);
    ALU_FUNC = F_MUL; Signed_Mode = 1'b0; A = 16'h1234; B = 16'h0010; Arith_Enable = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back({1'b1, 1'b0, 32'h00012340});
    wait_flag(edges, busy_cyc);
    check_result("mul_u", edges, busy_cyc, W);
    @(posedge CLK); #1;
    check("b2b_busy",  32'(Busy),       32'd1);
    check("b2b_pulse", 32'(Arith_Flag), 32'd0);
    Arith_Enable = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'h00012340});
    wait_flag(edges, busy_cyc);
    check_result("mul_u_b2b", edges, busy_cyc, W);
    run_op("mul_u_fit", F_MUL, 1'b0, 16'h00FF, 16'h0002, 32'h000001FE, 1'b0, 1'b0, W);

    // unsigned div and divide-by-zero
    run_op("div_u", F_DIV, 1'b0, 16'd100, 16'd7, 32'h0002000E, 1'b0, 1'b0, W);
    run_op("div_zero", F_DIV, 1'b0, 16'h00AB, 16'h0000, 32'h00ABFFFF, 1'b0, 1'b1, 0);

    // signed mode
    run_op("mul_s", F_MUL, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b0, 1'b0, W);
    run_op("div_s", F_DIV, 1'b1, 16'hFFF9, 16'h0002, 32'hFFFFFFFD, 1'b0, 1'b0, W);
    run_op("div_s_ovf", F_DIV, 1'b1, 16'h8000, 16'hFFFF, 32'h00008000, 1'b1, 1'b0, W);
    run_op("add_s_ovf", F_ADD, 1'b1, 16'h7FFF, 16'h0001, 32'h00008000, 1'b1, 1'b0, 0);
    run_op("sub_s_ok", F_SUB, 1'b1, 16'h0005, 16'h0003, 32'h00000002, 1'b0, 1'b0, 0);
    run_op("sub_s_ovf", F_SUB, 1'b1, 16'h8000, 16'h0001, 32'h00007FFF, 1'b1, 1'b0, 0);

    // busy protection: inputs change and Arith_Enable pulses mid-CALC
    f0 = flag_cnt;
    drive_start(F_MUL, 1'b0, 16'h0003, 16'h0005);
    @(negedge CLK);
    A = 16'hFFFF; B = 16'hFFFF; ALU_FUNC = F_ADD; Arith_Enable = 1'b1;
    @(negedge CLK);
    Arith_Enable = 1'b0;
    edges = 0;
    while (Arith_Flag !== 1'b1 && edges < 40) begin
      @(posedge CLK); #1;
      edges++;
    end
    check("busy_prot_flag", 32'(Arith_Flag), 32'd1);
    check("busy_prot_out",  Arith_OUT,       32'h0000000F);
    repeat (5) @(posedge CLK);
    #1;
    check("busy_prot_nflags", flag_cnt - f0, 32'd1);

    // asynchronous reset in the middle of a divide
    drive_start(F_DIV, 1'b0, 16'd100, 16'd7);
    f0 = flag_cnt;
    repeat (4) @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check("arst_out",   Arith_OUT,        32'h0);
    check("arst_carry", 32'(Carry_OUT),   32'd0);
    check("arst_flag",  32'(Arith_Flag),  32'd0);
    check("arst_busy",  32'(Busy),        32'd0);
    check("arst_dbz",   32'(Div_By_Zero), 32'd0);
    check("arst_state", 32'(state_dbg),   32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    check("arst_noflag", flag_cnt - f0, 32'd0);
    run_op("add_after_rst", F_ADD, 1'b0, 16'h0002, 16'h0003, 32'h00000005, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
